// File: rtl/uart_byte_rx.sv
// uart_byte_rx: UART receiver, 8N1 LSB first, 3-sample majority vote, 50 MHz clk.
//   clk, rst_n (async, active-low); rx (async serial in, idle high)
//   set_baud: 0:9600 1:19200 2:38400 3:57600 4:115200 else 9600 (latched per frame)
//   data_byte: last good byte; rx_done / frame_err: one-cycle pulses; busy: frame in progress
//   UART_RX_ERR_CNT_EN: adds err_cnt, a saturating count of frame errors and false starts
module uart_byte_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic [2:0] set_baud,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
`ifdef UART_RX_ERR_CNT_EN
  output logic [7:0] err_cnt,
`endif
  output logic       busy
);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
  logic [SYNC_STAGES-1:0] sync_q;
  logic rx_s, rx_d, start_edge, s0, s1, maj, resolve, boundary, false_start, bad_stop;
  logic [2:0] baud_q, idx;
  logic [19:0] cnt, cnt_max, mid;
  logic [1:0] state;
  logic [7:0] sh;
  assign rx_s = sync_q[SYNC_STAGES-1];
  assign start_edge = rx_d & ~rx_s;
  always_comb begin
    cnt_max = baud_q == 3'd1 ? 20'd2603 :
              baud_q == 3'd2 ? 20'd1301 :
              baud_q == 3'd3 ? 20'd867  :
              baud_q == 3'd4 ? 20'd433  : 20'd5207;
    mid = cnt_max >> 1;
    resolve = cnt == mid + 20'd1;
    boundary = cnt == cnt_max;
    maj = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    false_start = state == START && resolve && maj;
    bad_stop = state == STOP && resolve && !maj;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '1;
      rx_d <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rx_d <= rx_s;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      baud_q <= '0;
      idx <= '0;
      sh <= '0;
      s0 <= 1'b1;
      s1 <= 1'b1;
      data_byte <= '0;
      rx_done <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      frame_err <= 1'b0;
      if (cnt == mid - 20'd1) s0 <= rx_s;
      if (cnt == mid) s1 <= rx_s;
      if (state == IDLE) begin
        cnt <= '0;
        if (start_edge) begin
          state <= START;
          baud_q <= set_baud;
          busy <= 1'b1;
        end
      end else begin
        cnt <= boundary ? '0 : cnt + 20'd1;
        if (state == START) begin
          if (false_start) begin
            state <= IDLE;
            busy <= 1'b0;
            cnt <= '0;
          end else if (boundary) begin
            state <= DATA;
            idx <= '0;
          end
        end else if (state == DATA) begin
          if (resolve) sh[idx] <= maj;
          if (boundary) begin
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= STOP;
          end
        end else if (resolve) begin
          // leave at mid-stop so a start bit right after the stop bit is caught
          state <= IDLE;
          busy <= 1'b0;
          cnt <= '0;
          rx_done <= maj;
          frame_err <= ~maj;
          if (maj) data_byte <= sh;
        end
      end
    end
`ifdef UART_RX_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_cnt <= '0;
    else if ((false_start || bad_stop) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed frames against a queue of expected receive events.
module tb_uart_byte_rx;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
  logic [2:0] set_baud = 3'd0;
  logic [7:0] data_byte;
  logic rx_done, frame_err, busy;
  int checks = 0, errors = 0, n_done = 0, n_ferr = 0, exp_ecnt = 0;
  logic [7:0] model_data = 8'h00;
  typedef struct {logic err; logic [7:0] d;} ev_t;
  ev_t exp_q[$];
  ev_t e;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  uart_byte_rx #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .set_baud(set_baud),
    .data_byte(data_byte), .rx_done(rx_done), .frame_err(frame_err),
`ifdef UART_RX_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .busy(busy)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic err, input logic [7:0] d);
    ev_t x;
    x.err = err;
    x.d = d;
    exp_q.push_back(x);
  endtask

  // per = clocks per bit; glitch_bit: data bit inverted for one clk at its mid sample
  // chg_bit: data bit at which set_baud is changed; abort: reset during data bit 4
  task automatic send(input int per, input logic [7:0] b, input logic stop, input bit full_stop,
                      input int gap, input int glitch_bit, input int chg_bit,
                      input logic [2:0] new_baud, input bit abort);
    rx = 1'b0;
    tick(per);
    for (int i = 0; i < 8; i++) begin
      if (abort && i == 4) begin
        tick(per / 3);
        rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
        rx = 1'b1;
        tick(gap);
        return;
      end
      if (i == chg_bit) set_baud = new_baud;
      rx = b[i];
      if (i == glitch_bit) begin
        tick(per / 2);
        rx = ~b[i];
        tick(1);
        rx = b[i];
        tick(per - per / 2 - 1);
      end else tick(per);
    end
    rx = stop;
    tick(full_stop ? per : per / 2 + 30);
    rx = 1'b1;
    tick(gap);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_data = 8'h00;
      chk("reset_data", 32'(data_byte), 32'h0);
      chk("reset_flags", {29'h0, rx_done, frame_err, busy}, 32'h0);
    end else begin
      chk("done_err_exclusive", 32'(rx_done & frame_err), 32'h0);
      if (rx_done || frame_err) begin
        if (rx_done) n_done++;
        if (frame_err) n_ferr++;
        if (exp_q.size() == 0) chk("unexpected_pulse", {30'h0, rx_done, frame_err}, 32'h0);
        else begin
          e = exp_q.pop_front();
          chk("pulse_kind", 32'(frame_err), 32'(e.err));
          if (!e.err) model_data = e.d;
        end
      end
      chk("data_byte", 32'(data_byte), 32'(model_data));
    end
  end

  task automatic chk_ecnt();
`ifdef UART_RX_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt), 32'(exp_ecnt));
`endif
  endtask

  initial begin
    tick(5);
    rst_n = 1'b1;
    tick(5);
    chk_ecnt();
    set_baud = 3'd0;
    push(1'b0, 8'h55);
    send(5208, 8'h55, 1'b1, 1'b0, 20, -1, -1, 3'd0, 1'b0);
    chk("t1_done", 32'(n_done), 32'd1);
    chk("t1_ferr", 32'(n_ferr), 32'd0);
    chk("t1_data", 32'(data_byte), 32'h55);
    chk("t1_busy", 32'(busy), 32'd0);
    set_baud = 3'd4;
    push(1'b0, 8'h00);
    push(1'b0, 8'hFF);
    send(434, 8'h00, 1'b1, 1'b1, 0, -1, -1, 3'd0, 1'b0);
    send(434, 8'hFF, 1'b1, 1'b0, 20, -1, -1, 3'd0, 1'b0);
    chk("t2_done", 32'(n_done), 32'd3);
    chk("t2_ferr", 32'(n_ferr), 32'd0);
    chk("t2_data", 32'(data_byte), 32'hFF);
    rx = 1'b0;
    tick(50);
    chk("t3_busy_high", 32'(busy), 32'd1);
    tick(50);
    rx = 1'b1;
    tick(334);
    chk("t3_busy_low", 32'(busy), 32'd0);
    chk("t3_pulses", 32'(n_done + n_ferr), 32'd3);
    exp_ecnt = 1;
    chk_ecnt();
    set_baud = 3'd2;
    push(1'b1, 8'h00);
    send(1302, 8'hA3, 1'b0, 1'b0, 20, -1, -1, 3'd0, 1'b0);
    chk("t4_ferr", 32'(n_ferr), 32'd1);
    chk("t4_data_kept", 32'(data_byte), 32'hFF);
    exp_ecnt = 2;
    chk_ecnt();
    push(1'b0, 8'h3C);
    send(1302, 8'h3C, 1'b1, 1'b0, 20, -1, -1, 3'd0, 1'b0);
    chk("t4_data", 32'(data_byte), 32'h3C);
    chk("t4_done", 32'(n_done), 32'd4);
    set_baud = 3'd3;
    push(1'b0, 8'h0F);
    send(868, 8'h0F, 1'b1, 1'b0, 20, 1, -1, 3'd0, 1'b0);
    chk("t5_data", 32'(data_byte), 32'h0F);
    chk("t5_done", 32'(n_done), 32'd5);
    set_baud = 3'd4;
    send(434, 8'h5A, 1'b1, 1'b0, 50, -1, -1, 3'd0, 1'b1);
    chk("t6_reset_data", 32'(data_byte), 32'h00);
    chk("t6_no_pulse", 32'(n_done + n_ferr), 32'd6);
    chk("t6_busy", 32'(busy), 32'd0);
    exp_ecnt = 0;
    chk_ecnt();
    push(1'b0, 8'h81);
    send(434, 8'h81, 1'b1, 1'b0, 20, -1, 3, 3'd0, 1'b0);
    chk("t6_data", 32'(data_byte), 32'h81);
    chk("t6_done", 32'(n_done), 32'd6);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
